// File: rtl/temp_ctrl_pwm.sv
// Mains-synchronous heater PWM with on/off-hysteresis or proportional control.
// Each period restarts on a zero-cross falling edge; duty only changes there.
module temp_ctrl_pwm #(
  parameter int unsigned TEMP_W      = 8,
  parameter int unsigned CNT_W       = 20,
  parameter int unsigned UPDATE_DIV  = 17,
  parameter int unsigned ON_DUTY     = 20'h01000,
  parameter int unsigned HYST        = 2,
  parameter int unsigned GAIN_SHIFT  = 8,
  parameter int unsigned MAX_DUTY    = 20'h40000,
  parameter int unsigned OVER_MARGIN = 16
) (
  input  logic              clk_i,
  input  logic              rst,
  input  logic              zc_i,
  input  logic [TEMP_W-1:0] temp_i,
  input  logic [TEMP_W-1:0] setpoint_i,
  input  logic              mode_i,
  input  logic              enable_i,
  output logic              pwm_o,
  output logic              heating_o,
  output logic              fault_o
);

  localparam int unsigned EXT_W = CNT_W + TEMP_W;

  localparam logic [CNT_W-1:0]  ON_DUTY_C  = CNT_W'(ON_DUTY);
  localparam logic [EXT_W-1:0]  MAX_DUTY_X = EXT_W'(MAX_DUTY);
  localparam logic [TEMP_W:0]   HYST_C     = (TEMP_W+1)'(HYST);
  localparam logic [TEMP_W:0]   MARGIN_C   = (TEMP_W+1)'(OVER_MARGIN);

  logic                  s1, s2, s3;
  logic                  zc_fall;
  logic [UPDATE_DIV-1:0] div;
  logic                  tick;
  logic [CNT_W-1:0]      cnt;
  logic [CNT_W-1:0]      duty;
  logic [CNT_W-1:0]      duty_next;
  logic [CNT_W-1:0]      calc_duty;
  logic                  fault;
  logic                  fault_next;

  logic [TEMP_W:0]        temp_x;
  logic [TEMP_W:0]        sp_x;
  logic [TEMP_W:0]        lo_thr;
  logic signed [TEMP_W:0] err;
  logic                   err_pos;
  logic [EXT_W-1:0]       prop_raw;
  logic [CNT_W-1:0]       prop_duty;
  logic                   over_temp;
  logic                   lost_zc;

  // zc_i is asynchronous to clk_i; the extra stage gives edge detection on
  // settled samples only.
  always_ff @(posedge clk_i or posedge rst) begin
    // NOTE: sequential state uses <= so every flop samples pre-edge values.
    if (rst) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= zc_i;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign zc_fall = s3 & ~s2;

  always_ff @(posedge clk_i or posedge rst) begin
    if (rst) div <= '0;
    else     div <= div + UPDATE_DIV'(1);
  end

  assign tick = &div;

  // Widened compares keep setpoint - HYST and setpoint + margin exact.
  assign temp_x   = {1'b0, temp_i};
  assign sp_x     = {1'b0, setpoint_i};
  assign lo_thr   = (sp_x >= HYST_C) ? (sp_x - HYST_C) : '0;
  assign err      = $signed(sp_x - temp_x);
  assign err_pos  = ~err[TEMP_W] && (err != '0);
  assign prop_raw = EXT_W'(err[TEMP_W-1:0]) << GAIN_SHIFT;
  assign prop_duty = (prop_raw > MAX_DUTY_X) ? MAX_DUTY_X[CNT_W-1:0]
                                             : prop_raw[CNT_W-1:0];

  always_comb begin
    // NOTE: defaulting to the held value first keeps this purely combinational.
    calc_duty = duty_next;
    if (setpoint_i == '0)    calc_duty = '0;
    else if (mode_i)         calc_duty = err_pos ? prop_duty : '0;
    else if (temp_x < lo_thr) calc_duty = ON_DUTY_C;
    else if (temp_x >= sp_x)  calc_duty = '0;
  end

  assign over_temp  = tick && (setpoint_i != '0) && (temp_x >= sp_x + MARGIN_C);
  assign lost_zc    = enable_i && (&cnt);
  assign fault_next = enable_i & (fault | over_temp | lost_zc);

  always_ff @(posedge clk_i or posedge rst) begin
    if (rst) begin
      fault     <= 1'b0;
      duty_next <= '0;
    end else begin
      fault <= fault_next;
      if (fault)     duty_next <= '0;
      else if (tick) duty_next <= calc_duty;
    end
  end

  // Counter saturates so a missing zero-cross is seen as all-ones, not a wrap.
  always_ff @(posedge clk_i or posedge rst) begin
    if (rst) begin
      cnt  <= '0;
      duty <= '0;
    end else if (zc_fall) begin
      cnt  <= '0;
      duty <= duty_next;
    end else if (!(&cnt)) begin
      cnt  <= cnt + CNT_W'(1);
    end
  end

  // Gate off on the same edge the fault flag rises.
  always_ff @(posedge clk_i or posedge rst) begin
    if (rst) pwm_o <= 1'b0;
    else     pwm_o <= enable_i & ~fault_next & (cnt < duty);
  end

  assign heating_o = (duty_next != '0);
  assign fault_o   = fault;

endmodule

// File: tb/tb_temp_ctrl_pwm.sv
// Directed bench for temp_ctrl_pwm: pulse lengths go through a scoreboard
// queue checked by a monitor; a second small-counter instance covers lost zero-cross.
module tb_temp_ctrl_pwm;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       zc  = 1'b1;
  logic [7:0] temp = 8'd97;
  logic [7:0] setpoint = 8'd100;
  logic       mode = 1'b0;
  logic       enable = 1'b1;
  logic       pwm, heating, fault;

  logic       pwm_lz, heating_lz, fault_lz;

  int unsigned total = 0;
  int unsigned bad   = 0;
  int unsigned cyc   = 0;
  int unsigned exp_q[$];
  logic        lz_done = 1'b0;

  always #5 clk = ~clk;

  temp_ctrl_pwm #(
    .TEMP_W(8), .CNT_W(16), .UPDATE_DIV(6), .ON_DUTY(200), .HYST(2),
    .GAIN_SHIFT(8), .MAX_DUTY(32'h8000), .OVER_MARGIN(16)
  ) dut (
    .clk_i(clk), .rst(rst), .zc_i(zc), .temp_i(temp), .setpoint_i(setpoint),
    .mode_i(mode), .enable_i(enable), .pwm_o(pwm), .heating_o(heating),
    .fault_o(fault)
  );

  temp_ctrl_pwm #(
    .TEMP_W(8), .CNT_W(12), .UPDATE_DIV(6), .ON_DUTY(200), .HYST(2),
    .GAIN_SHIFT(8), .MAX_DUTY(32'hfff), .OVER_MARGIN(16)
  ) dut_lz (
    .clk_i(clk), .rst(rst), .zc_i(1'b1), .temp_i(8'd0), .setpoint_i(8'd0),
    .mode_i(1'b0), .enable_i(1'b1), .pwm_o(pwm_lz), .heating_o(heating_lz),
    .fault_o(fault_lz)
  );

  // Edges since reset release; lines up stimulus with the update tick.
  always @(posedge clk) cyc <= rst ? 0 : cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", name, act, req);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic zc_period(input int len);
    zc = 1'b0;
    step(4);
    zc = 1'b1;
    step(len - 4);
  endtask

  // Monitor: every completed high pulse is matched against the next expectation.
  initial begin
    int unsigned hi;
    int unsigned req;
    hi = 0;
    forever begin
      @(negedge clk);
      if (rst) hi = 0;
      else if (pwm) hi++;
      else if (hi != 0) begin
        if (exp_q.size() == 0) check("pulse_unexpected", hi, 0);
        else begin
          req = exp_q.pop_front();
          check("pulse_len", hi, req);
        end
        hi = 0;
      end
    end
  end

  // Lost zero-cross on the 12-bit instance: cnt hits 4095 after edge 4095.
  initial begin
    @(negedge rst);
    do begin
      @(posedge clk);
      #1;
    end while (cyc != 4095);
    check("lz_before", fault_lz, 1'b0);
    step(1);
    check("lz_fault", fault_lz, 1'b1);
    check("lz_pwm", pwm_lz, 1'b0);
    check("lz_heat", heating_lz, 1'b0);
    lz_done = 1'b1;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    int temps [5] = '{97, 99, 100, 98, 97};
    logic heats [5] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1};

    step(1);
    // Reset with mains running: everything stays quiet.
    repeat (2) begin
      zc = 1'b0;
      repeat (2) begin
        step(250);
        check("rst_pwm", pwm, 1'b0);
        check("rst_heat", heating, 1'b0);
        check("rst_fault", fault, 1'b0);
      end
      zc = 1'b1;
      repeat (2) begin
        step(250);
        check("rst_pwm", pwm, 1'b0);
        check("rst_heat", heating, 1'b0);
        check("rst_fault", fault, 1'b0);
      end
    end
    rst = 1'b0;
    zc_period(50);
    check("idle_pwm", pwm, 1'b0);
    step(30);
    check("first_tick_heat", heating, 1'b1);
    check("idle_pwm2", pwm, 1'b0);

    // On/off hysteresis around setpoint 100, band 98..99 holds.
    for (int i = 0; i < 5; i++) begin
      temp = 8'(temps[i]);
      step(70);
      check("onoff_heat", heating, heats[i]);
      repeat (2) begin
        if (heats[i]) exp_q.push_back(200);
        zc_period(300);
      end
    end

    // Proportional duty (observed on the duty_next register).
    mode = 1'b1;
    temp = 8'd90;
    step(70);
    check("prop_90", dut.duty_next, 32'h0A00);
    check("prop_90_heat", heating, 1'b1);
    temp = 8'd0;
    step(70);
    check("prop_0", dut.duty_next, 32'h6400);
    setpoint = 8'd255;
    step(70);
    check("prop_sat", dut.duty_next, 32'h8000);
    setpoint = 8'd100;
    temp = 8'd101;
    step(70);
    check("prop_neg", dut.duty_next, 32'h0);
    check("prop_neg_heat", heating, 1'b0);

    // Tick coincides with zc_fall while temp moves 90 -> 95.
    temp = 8'd90;
    step(70);
    while (cyc[5:0] != 6'd61) step(1);
    exp_q.push_back(32'h0A00);
    zc = 1'b0;
    temp = 8'd95;
    step(4);
    zc = 1'b1;
    step(2996);
    exp_q.push_back(32'h0500);
    zc_period(3000);

    // Over-temperature: 116 >= 100 + 16 trips at the tick edge.
    temp = 8'd116;
    while (cyc[5:0] != 6'd63) step(1);
    check("ot_before", fault, 1'b0);
    step(1);
    check("ot_fault", fault, 1'b1);
    check("ot_pwm", pwm, 1'b0);
    temp = 8'd50;
    step(70);
    check("ot_sticky", fault, 1'b1);
    check("ot_heat", heating, 1'b0);
    zc_period(300);
    check("ot_pwm2", pwm, 1'b0);
    enable = 1'b0;
    step(1);
    check("ot_clear", fault, 1'b0);
    enable = 1'b1;
    step(70);
    check("ot_after", fault, 1'b0);
    check("ot_resume", dut.duty_next, 32'h3200);

    for (int i = 0; i < 10000 && !lz_done; i++) step(1);
    if (!lz_done) check("lz_timeout", 1'b0, 1'b1);
    step(10);
    check("queue_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
